multi_channel_adc_model: RTL and testbench
==========================================

Name: multi_channel_adc_model

Overview:
- Parametrised, synthesizable behavioural model of a multi-channel successive-approximation ADC.
- Used as the bus-side ADC peripheral in SoC simulation.
- Samples one of NUM_CH digitised "analog" inputs on trigger, or scans all channels in turn.
- Holds each result with a valid/ack handshake, flags overruns, and exposes a packed status word for the bus wrapper.

Parameters:
- DATA_WIDTH, 32: width of measurement and status_reg; must be >= 32.
- NUM_CH, 4: number of input channels, 1..256.
- SAMPLE_WIDTH, 12: resolution of each sample, 1..16.
- CONV_CYCLES, 16: clock cycles from sample to result, >= 2.

Ports:
- clk  in  1  single system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- adc_trigger  in  1  start request; sampled only in IDLE.
- mode  in  1  0 = single channel, 1 = scan ch 0..NUM_CH-1.
- ch_sel  in  CH_IDX_W  channel for single mode; latched at trigger.
- analog_in  in  NUM_CH*SAMPLE_WIDTH  channel k at bits [k*SAMPLE_WIDTH +: SAMPLE_WIDTH].
- meas_ack  in  1  consumer accepts the current measurement.
- measurement  out  DATA_WIDTH  [SAMPLE_WIDTH-1:0] = sample (zero-extended to bit 15), [23:16] = channel, remaining bits 0.
- meas_valid  out  1  measurement holds an unacknowledged result.
- status_reg  out  DATA_WIDTH  bit0 busy, bit1 meas_valid, bit2 overrun, bit3 oversample build flag, [15:8] last converted channel, [31:16] conversion count; other bits 0.

Behaviour:
- Reset (synchronous, active-high): state IDLE; measurement, meas_valid, overrun, last channel and count all 0. Reset takes priority over every other input, including mid-conversion; a partial result is discarded.
- CH_IDX_W = max(1, clog2(NUM_CH)). A ch_sel value >= NUM_CH is clamped to NUM_CH-1.
- FSM states:
  - IDLE: busy = 0. adc_trigger = 1 latches mode and channel (0 in scan mode), clears overrun, and goes to SAMPLE.
  - SAMPLE: one cycle; captures analog_in[channel] into the holding register; goes to CONVERT.
  - CONVERT: down-counter runs CONV_CYCLES-1 cycles; at zero goes to RESULT.
  - RESULT: one cycle; loads measurement, sets meas_valid, increments count (16-bit, wraps 0xFFFF -> 0), updates last channel. In scan mode with channel < NUM_CH-1, increments channel and goes to SAMPLE; otherwise goes to IDLE.
- Latency: meas_valid rises CONV_CYCLES+1 edges after the edge that samples adc_trigger. A scan delivers one result every CONV_CYCLES+1 cycles.
- adc_trigger outside IDLE is ignored and has no side effects.
- meas_ack while meas_valid = 1 clears meas_valid on the next edge; measurement keeps its value. meas_ack while meas_valid = 0 is ignored.
- Ack and new result in the same cycle: the new result wins; meas_valid stays 1; no overrun.
- New result while meas_valid = 1 and no ack that cycle: measurement is overwritten and overrun is set (sticky until the next accepted trigger or reset).
- mode, ch_sel and analog_in are don't-care except at the edges where they are sampled.

Optional Feature:
- Macro: ADC_OVERSAMPLE_EN.
- When defined, each channel conversion repeats SAMPLE+CONVERT four times, accumulating into a SAMPLE_WIDTH+2-bit sum. The result is sum >> 2 (truncating). Latency per channel becomes 4*CONV_CYCLES+1. Status bit3 reads 1.
- When undefined, there is a single sample per conversion, no accumulator logic, and status bit3 reads 0.

Decomposition:
- Shared package adc_pkg holds:
  - FSM state enum: IDLE, SAMPLE, CONVERT, RESULT.
  - Status bit index constants: STAT_BUSY = 0, STAT_VALID = 1, STAT_OVR = 2, STAT_OVS = 3.
  - Field offsets: STAT_CH_LSB = 8, STAT_CNT_LSB = 16, MEAS_CH_LSB = 16.
- One sub-module, adc_result_hold: owns the measurement register, meas_valid, the ack logic and overrun detection.

Test Plan:
- Reset values: hold reset for 2 cycles -> measurement = 0, meas_valid = 0, status_reg = 0 (0x8 with ADC_OVERSAMPLE_EN); busy = 0.
- Single conversion: mode = 0, ch_sel = 2, channel 2 = 0xABC, one-cycle trigger -> meas_valid rises exactly 17 edges later; measurement = 0x00020ABC; status = 0x00010202 (busy 0, valid 1, last ch 2, count 1).
- Scan with ack: mode = 1, channels = 0x111, 0x222, 0x333, 0x444, ack each result -> four results 0x00000111, 0x00010222, 0x00020333, 0x00030444 at 17-cycle spacing; count = 4; overrun = 0.
- Overrun and ignored trigger: scan with no acks, and re-pulse adc_trigger while busy -> final measurement = 0x00030444, overrun = 1, count = 4 (the extra trigger has no effect); the next trigger clears overrun.
- Reset mid-conversion: assert reset at CONVERT cycle 5 -> next cycle is IDLE with all outputs 0; a fresh trigger then completes normally with count = 1.
- ADC_OVERSAMPLE_EN: channel 0 driven to 0x100, 0x102, 0x104, 0x106 across the four sample edges -> measurement = 0x00000103, valid at edge 65 after the trigger.

Source files
------------

// File: rtl/adc_pkg.sv
// Shared types and field positions for the multi-channel ADC model.
package adc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAMPLE  = 2'd1,
    CONVERT = 2'd2,
    RESULT  = 2'd3
  } adc_state_e;

  localparam int unsigned STAT_BUSY  = 0;
  localparam int unsigned STAT_VALID = 1;
  localparam int unsigned STAT_OVR   = 2;
  localparam int unsigned STAT_OVS   = 3;

  localparam int unsigned STAT_CH_LSB  = 8;
  localparam int unsigned STAT_CNT_LSB = 16;
  localparam int unsigned MEAS_CH_LSB  = 16;

  localparam int unsigned CH_FIELD_W  = 8;
  localparam int unsigned CNT_FIELD_W = 16;

endpackage

// File: rtl/adc_result_hold.sv
// Result holding register: measurement word, valid/ack handshake and sticky overrun.
module adc_result_hold
  import adc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned SAMPLE_WIDTH = 12
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [SAMPLE_WIDTH-1:0] sample,
  input  logic [CH_FIELD_W-1:0]   ch,
  input  logic                    meas_ack,
  input  logic                    clr_ovr,
  output logic [DATA_WIDTH-1:0]   measurement,
  output logic                    meas_valid,
  output logic                    overrun
);

  logic [DATA_WIDTH-1:0] meas_q, meas_d;
  logic                  valid_q, valid_d;
  logic                  ovr_q, ovr_d;

  // A new result always wins over a same-cycle ack; overrun only when it lands unacked.
  always_comb begin
    meas_d  = meas_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (clr_ovr) ovr_d = 1'b0;
    if (load) begin
      meas_d                            = '0;
      meas_d[SAMPLE_WIDTH-1:0]          = sample;
      meas_d[MEAS_CH_LSB +: CH_FIELD_W] = ch;
      valid_d                           = 1'b1;
      if (valid_q && !meas_ack) ovr_d = 1'b1;
    end else if (meas_ack) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meas_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      meas_q  <= meas_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign measurement = meas_q;
  assign meas_valid  = valid_q;
  assign overrun     = ovr_q;

endmodule

// File: rtl/multi_channel_adc_model.sv
// Multi-channel SAR ADC behavioural model: single/scan sequencing and status word.
// Optional 4x oversampling per channel is enabled by defining ADC_OVERSAMPLE_EN.
module multi_channel_adc_model
  import adc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned SAMPLE_WIDTH = 12,
  parameter int unsigned CONV_CYCLES  = 16,
  localparam int unsigned CH_IDX_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           adc_trigger,
  input  logic                           mode,
  input  logic [CH_IDX_W-1:0]            ch_sel,
  input  logic [NUM_CH*SAMPLE_WIDTH-1:0] analog_in,
  input  logic                           meas_ack,
  output logic [DATA_WIDTH-1:0]          measurement,
  output logic                           meas_valid,
  output logic [DATA_WIDTH-1:0]          status_reg
);

  localparam int unsigned CNT_W = (CONV_CYCLES > 2) ? $clog2(CONV_CYCLES) : 1;
`ifdef ADC_OVERSAMPLE_EN
  localparam int unsigned ACC_W    = SAMPLE_WIDTH + 2;
  localparam logic        OVS_FLAG = 1'b1;
`else
  localparam int unsigned ACC_W    = SAMPLE_WIDTH;
  localparam logic        OVS_FLAG = 1'b0;
`endif

  adc_state_e              state_q, state_d;
  logic                    mode_q, mode_d;
  logic [CH_IDX_W-1:0]     ch_q, ch_d;
  logic [CH_IDX_W-1:0]     last_ch_q, last_ch_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ACC_W-1:0]        samp_q, samp_d;
  logic [CNT_FIELD_W-1:0]  count_q, count_d;
  logic [SAMPLE_WIDTH-1:0] sel_sample_c, result_c;
  logic [CH_IDX_W-1:0]     ch_clamp_c;
  logic                    load_c, clr_ovr_c, overrun;
`ifdef ADC_OVERSAMPLE_EN
  logic [1:0]              pass_q, pass_d;
`endif

  assign sel_sample_c = analog_in[32'(ch_q)*SAMPLE_WIDTH +: SAMPLE_WIDTH];
  assign ch_clamp_c   = (32'(ch_sel) >= NUM_CH) ? CH_IDX_W'(NUM_CH - 1) : ch_sel;
`ifdef ADC_OVERSAMPLE_EN
  assign result_c = SAMPLE_WIDTH'(samp_q >> 2);
`else
  assign result_c = samp_q;
`endif

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    ch_d      = ch_q;
    last_ch_d = last_ch_q;
    cnt_d     = cnt_q;
    samp_d    = samp_q;
    count_d   = count_q;
    load_c    = 1'b0;
    clr_ovr_c = 1'b0;
`ifdef ADC_OVERSAMPLE_EN
    pass_d    = pass_q;
`endif
    case (state_q)
      IDLE: begin
        if (adc_trigger) begin
          mode_d    = mode;
          ch_d      = mode ? '0 : ch_clamp_c;
          clr_ovr_c = 1'b1;
          state_d   = SAMPLE;
`ifdef ADC_OVERSAMPLE_EN
          pass_d    = 2'd0;
`endif
        end
      end
      SAMPLE: begin
`ifdef ADC_OVERSAMPLE_EN
        samp_d = (pass_q == 2'd0) ? ACC_W'(sel_sample_c) : samp_q + ACC_W'(sel_sample_c);
`else
        samp_d = sel_sample_c;
`endif
        // Loaded so CONVERT lasts CONV_CYCLES-1 cycles including the zero cycle.
        cnt_d   = CNT_W'(CONV_CYCLES - 2);
        state_d = CONVERT;
      end
      CONVERT: begin
        if (cnt_q == '0) begin
`ifdef ADC_OVERSAMPLE_EN
          if (pass_q == 2'd3) begin
            state_d = RESULT;
          end else begin
            pass_d  = pass_q + 2'd1;
            state_d = SAMPLE;
          end
`else
          state_d = RESULT;
`endif
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESULT: begin
        load_c    = 1'b1;
        count_d   = count_q + CNT_FIELD_W'(1);
        last_ch_d = ch_q;
        if (mode_q && (32'(ch_q) < NUM_CH - 1)) begin
          ch_d    = ch_q + CH_IDX_W'(1);
          state_d = SAMPLE;
`ifdef ADC_OVERSAMPLE_EN
          pass_d  = 2'd0;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      mode_q    <= 1'b0;
      ch_q      <= '0;
      last_ch_q <= '0;
      cnt_q     <= '0;
      samp_q    <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      ch_q      <= ch_d;
      last_ch_q <= last_ch_d;
      cnt_q     <= cnt_d;
      samp_q    <= samp_d;
      count_q   <= count_d;
    end
  end

`ifdef ADC_OVERSAMPLE_EN
  always_ff @(posedge clk) begin
    if (reset) pass_q <= 2'd0;
    else       pass_q <= pass_d;
  end
`endif

  adc_result_hold #(
    .DATA_WIDTH   (DATA_WIDTH),
    .SAMPLE_WIDTH (SAMPLE_WIDTH)
  ) u_hold (
    .clk         (clk),
    .reset       (reset),
    .load        (load_c),
    .sample      (result_c),
    .ch          (CH_FIELD_W'(ch_q)),
    .meas_ack    (meas_ack),
    .clr_ovr     (clr_ovr_c),
    .measurement (measurement),
    .meas_valid  (meas_valid),
    .overrun     (overrun)
  );

  // Status word assembled purely from registered state.
  always_comb begin
    status_reg                                = '0;
    status_reg[STAT_BUSY]                     = (state_q != IDLE);
    status_reg[STAT_VALID]                    = meas_valid;
    status_reg[STAT_OVR]                      = overrun;
    status_reg[STAT_OVS]                      = OVS_FLAG;
    status_reg[STAT_CH_LSB +: CH_FIELD_W]     = CH_FIELD_W'(last_ch_q);
    status_reg[STAT_CNT_LSB +: CNT_FIELD_W]   = count_q;
  end

endmodule

// File: tb/tb_multi_channel_adc_model.sv
// Randomised self-checking bench for multi_channel_adc_model against a transaction-level model.
module tb_multi_channel_adc_model;

  localparam int unsigned NCH = 4;
  localparam int unsigned SW  = 12;
  localparam int unsigned CC  = 16;
`ifdef ADC_OVERSAMPLE_EN
  localparam int unsigned PASSES  = 4;
  localparam logic [31:0] OVS_BIT = 32'h8;
`else
  localparam int unsigned PASSES  = 1;
  localparam logic [31:0] OVS_BIT = 32'h0;
`endif
  localparam int unsigned LAT  = PASSES * CC + 1;
  localparam int unsigned LAT2 = PASSES * 2 + 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              adc_trigger = 1'b0, mode = 1'b0, meas_ack = 1'b0;
  logic [1:0]        ch_sel = '0;
  logic [NCH*SW-1:0] analog_in = '0;
  logic [31:0]       measurement, status_reg;
  logic              meas_valid;

  logic              trig2 = 1'b0, mode2 = 1'b0, ack2 = 1'b0;
  logic [1:0]        ch_sel2 = '0;
  logic [3*SW-1:0]   analog2 = '0;
  logic [31:0]       meas2, stat2;
  logic              valid2;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model state
  logic [SW-1:0] chan_val [NCH];
  logic [15:0]   m_count;
  int            m_last_ch;
  bit            m_valid, m_ovr;
  logic [31:0]   m_meas;

  always #5 clk = ~clk;

  multi_channel_adc_model dut (
    .clk(clk), .reset(reset), .adc_trigger(adc_trigger), .mode(mode), .ch_sel(ch_sel),
    .analog_in(analog_in), .meas_ack(meas_ack), .measurement(measurement),
    .meas_valid(meas_valid), .status_reg(status_reg)
  );

  multi_channel_adc_model #(.NUM_CH(3), .CONV_CYCLES(2)) dut2 (
    .clk(clk), .reset(reset), .adc_trigger(trig2), .mode(mode2), .ch_sel(ch_sel2),
    .analog_in(analog2), .meas_ack(ack2), .measurement(meas2),
    .meas_valid(valid2), .status_reg(stat2)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [31:0] exp_status(input bit busy);
    return OVS_BIT | {m_count, 8'(m_last_ch), 4'b0, 1'b0, m_ovr, m_valid, busy};
  endfunction

  task automatic set_analog();
    for (int k = 0; k < NCH; k++) analog_in[k*SW +: SW] = chan_val[k];
  endtask

  task automatic model_reset();
    m_count = '0; m_last_ch = 0; m_valid = 0; m_ovr = 0; m_meas = '0;
  endtask

  task automatic model_result(input int ch, input logic [SW-1:0] val);
    m_ovr     = m_ovr | m_valid;
    m_count   = m_count + 16'd1;
    m_last_ch = ch;
    m_valid   = 1;
    m_meas    = 32'(val) | (32'(ch) << 16);
  endtask

  // Waits for the conversion count to advance; bounded so a stuck DUT cannot hang the run.
  task automatic wait_result();
    logic [15:0] prev;
    prev = m_count;
    for (int n = 0; n < 4 * LAT && status_reg[31:16] == prev; n++) tick();
  endtask

  task automatic run_txn(input bit md, input int sel, input int ack_mask, input bit retrig);
    int ch0, nres, t0;
    ch0  = md ? 0 : ((sel >= int'(NCH)) ? int'(NCH) - 1 : sel);
    nres = md ? int'(NCH) : 1;
    mode = md; ch_sel = 2'(sel); adc_trigger = 1'b1;
    tick();
    adc_trigger = 1'b0;
    t0 = cyc;
    m_ovr = 0;
    check_eq("trig_status", status_reg, exp_status(1));
    if (retrig) begin
      mode = ~md; ch_sel = 2'($urandom_range(0, 3)); adc_trigger = 1'b1;
      tick();
      adc_trigger = 1'b0;
    end
    for (int r = 0; r < nres; r++) begin
      wait_result();
      check_eq("latency", 32'(cyc - t0), 32'((r + 1) * int'(LAT)));
      model_result(ch0 + r, chan_val[ch0 + r]);
      check_eq("meas", measurement, m_meas);
      check_eq("valid", 32'(meas_valid), 32'(m_valid));
      check_eq("status", status_reg, exp_status(r < nres - 1));
      if (ack_mask[r]) begin
        meas_ack = 1'b1;
        tick();
        meas_ack = 1'b0;
        m_valid = 0;
        check_eq("ack_valid", 32'(meas_valid), 32'(m_valid));
        check_eq("ack_meas_kept", measurement, m_meas);
      end
    end
    check_eq("end_status", status_reg, exp_status(0));
  endtask

  initial begin
    model_reset();
    tick();
    tick();
    check_eq("rst_meas", measurement, 32'h0);
    check_eq("rst_valid", 32'(meas_valid), 32'h0);
    check_eq("rst_status", status_reg, OVS_BIT);
    reset = 1'b0;

    // Clamped channel select and minimum conversion length on the 3-channel instance
    analog2 = {12'h0C3, 12'h0B2, 12'h0A1};
    ch_sel2 = 2'd3; trig2 = 1'b1;
    tick();
    trig2 = 1'b0;
    begin
      int t0;
      t0 = cyc;
      for (int n = 0; n < 50 && !valid2; n++) tick();
      check_eq("clamp_latency", 32'(cyc - t0), 32'(LAT2));
      check_eq("clamp_meas", meas2, 32'h000200C3);
      check_eq("clamp_status", stat2, OVS_BIT | 32'h00010202);
    end

    // Single conversion on channel 2
    chan_val[0] = 12'h111; chan_val[1] = 12'h222; chan_val[2] = 12'hABC; chan_val[3] = 12'h444;
    set_analog();
    run_txn(0, 2, 0, 0);
    check_eq("single_meas", measurement, 32'h00020ABC);
    check_eq("single_status", status_reg, OVS_BIT | 32'h00010202);
    meas_ack = 1'b1;
    tick();
    meas_ack = 1'b0;
    m_valid = 0;
    check_eq("single_ack", 32'(meas_valid), 32'h0);

    // Scan with acks, then scan without acks plus an ignored re-trigger
    chan_val[2] = 12'h333;
    set_analog();
    run_txn(1, 0, 'hF, 0);
    check_eq("scan_ack_ovr", 32'(status_reg[2]), 32'h0);
    run_txn(1, 3, 0, 1);
    check_eq("scan_noack_meas", measurement, 32'h00030444);
    check_eq("scan_noack_ovr", 32'(status_reg[2]), 32'h1);

    // Randomised transactions
    for (int i = 0; i < 25; i++) begin
      for (int k = 0; k < int'(NCH); k++) chan_val[k] = SW'($urandom);
      set_analog();
      if (!m_valid && $urandom_range(0, 1) == 1) begin
        meas_ack = 1'b1;
        tick();
        meas_ack = 1'b0;
        check_eq("idle_ack_ignored", status_reg, exp_status(0));
      end
      run_txn(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom), 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a conversion discards everything
    mode = 1'b0; ch_sel = 2'd1; adc_trigger = 1'b1;
    tick();
    adc_trigger = 1'b0;
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    check_eq("midrst_meas", measurement, 32'h0);
    check_eq("midrst_valid", 32'(meas_valid), 32'h0);
    check_eq("midrst_status", status_reg, OVS_BIT);
    run_txn(0, 1, 1, 0);
    check_eq("midrst_count", 32'(status_reg[31:16]), 32'h1);

`ifdef ADC_OVERSAMPLE_EN
    // Four differing samples on channel 0 averaged with truncation
    begin
      int t0;
      analog_in[SW-1:0] = 12'h100;
      mode = 1'b0; ch_sel = 2'd0; adc_trigger = 1'b1;
      tick();
      adc_trigger = 1'b0;
      t0 = cyc;
      m_ovr = 0;
      tick();
      analog_in[SW-1:0] = 12'h102;
      repeat (CC) tick();
      analog_in[SW-1:0] = 12'h104;
      repeat (CC) tick();
      analog_in[SW-1:0] = 12'h106;
      wait_result();
      check_eq("ovs_latency", 32'(cyc - t0), 32'd65);
      model_result(0, 12'h103);
      check_eq("ovs_meas", measurement, 32'h00000103);
      check_eq("ovs_status", status_reg, exp_status(0));
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
